// File: rtl/dpsk_pkg.sv
// Shared types and defaults for the DPSK word deframer.
// State encoding, word/sync defaults, error counter width.
package dpsk_pkg;
  typedef enum logic [1:0] {
    HUNT,
    DATA,
    CHECK
  } state_t;

  localparam int         WORD_W_DEF    = 8;
  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
  localparam int         ERR_W         = 8;
endpackage

// File: rtl/dpsk_word_deframer_if.sv
// Word delivery handshake: word_out/word_sof qualified by
// word_valid, accepted on word_valid && word_ready.
interface dpsk_word_deframer_if #(
  parameter int W = 8
);
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready;
  logic         word_sof;

  modport master (
    output word_out,
    output word_valid,
    output word_sof,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
    input  word_sof,
    output word_ready
  );
endinterface

// File: rtl/dpsk_out_reg.sv
// One-entry valid/ready holding register with sticky overflow.
// Ports: clk1/rst, load_i/data_i/sof_i, clr_i, wif (master), overflow_o.
module dpsk_out_reg #(
  parameter int W = 8
) (
  input  logic         clk1,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         sof_i,
  input  logic         clr_i,
  dpsk_word_deframer_if.master wif,
  output logic         overflow_o
);
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         sof_q, sof_d;
  logic         ovf_q, ovf_d;
  logic         xfer, take, drop;

  // A load may reuse the slot being handed off this cycle.
  always_comb begin
    xfer    = valid_q && wif.word_ready;
    take    = load_i && (!valid_q || wif.word_ready);
    drop    = load_i && valid_q && !wif.word_ready;
    data_d  = data_q;
    sof_d   = sof_q;
    valid_d = valid_q;
    if (take) begin
      data_d  = data_i;
      sof_d   = sof_i;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    // A drop in the same cycle as clr still sets the flag.
    ovf_d = clr_i ? 1'b0 : ovf_q;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wif.word_out   = data_q;
  assign wif.word_valid = valid_q;
  assign wif.word_sof   = sof_q;
  assign overflow_o     = ovf_q;
endmodule

// File: rtl/dpsk_word_deframer.sv
// Sync hunt, flywheel check and MSB-first word packing of demod bits.
// Ports: clk1/rst, bit inputs, clr, wif (words), locked, overflow, err_cnt.
module dpsk_word_deframer
  import dpsk_pkg::*;
#(
  parameter int                WORD_W    = WORD_W_DEF,
  parameter logic [WORD_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int                FRAME_LEN = 4,
  parameter int                MISS_MAX  = 3
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             demodulated,
  input  logic             neg_demodulated,
  input  logic             bit_valid,
  input  logic             clr,
  dpsk_word_deframer_if.master wif,
  output logic             locked,
  output logic             overflow,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int BC_W = $clog2(WORD_W);
  localparam int WC_W = $clog2(FRAME_LEN + 1);
  localparam int MC_W = $clog2(MISS_MAX + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(FRAME_LEN - 1);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MISS_MAX - 1);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d, sr_nx;
  logic [BC_W-1:0]   bit_q, bit_d;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic [MC_W-1:0]   miss_q, miss_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              done, sof;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    wc_d    = wc_q;
    miss_d  = miss_q;
    done    = 1'b0;
    sof     = 1'b0;
    sr_nx   = {sr_q[WORD_W-2:0], demodulated};
    if (bit_valid) begin
      sr_d = sr_nx;
      unique case (state_q)
        HUNT: begin
          if (sr_nx == SYNC_WORD) begin
            state_d = DATA;
            bit_d   = '0;
            wc_d    = '0;
            miss_d  = '0;
          end
        end
        DATA: begin
          if (bit_q == BC_LAST) begin
            done  = 1'b1;
            sof   = (wc_q == '0);
            bit_d = '0;
            if (wc_q == WC_LAST) begin
              state_d = CHECK;
              wc_d    = '0;
            end else begin
              wc_d = wc_q + 1'b1;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        CHECK: begin
          if (bit_q == BC_LAST) begin
            bit_d = '0;
            if (sr_nx == SYNC_WORD) begin
              miss_d  = '0;
              state_d = DATA;
            end else if (miss_q == MC_LAST) begin
              miss_d  = '0;
              state_d = HUNT;
            end else begin
              // Flywheel: keep the assumed frame alignment.
              miss_d  = miss_q + 1'b1;
              state_d = DATA;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // A new error in the same cycle as clr counts from zero.
  always_comb begin
    err_d = clr ? '0 : err_q;
    if (bit_valid && (demodulated == neg_demodulated)
        && (err_d != '1))
      err_d = err_d + 1'b1;
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      sr_q    <= '0;
      bit_q   <= '0;
      wc_q    <= '0;
      miss_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      wc_q    <= wc_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
    end
  end

  dpsk_out_reg #(
    .W(WORD_W)
  ) u_out (
    .clk1      (clk1),
    .rst       (rst),
    .load_i    (done),
    .data_i    (sr_nx),
    .sof_i     (sof),
    .clr_i     (clr),
    .wif       (wif),
    .overflow_o(overflow)
  );

  assign locked  = (state_q != HUNT);
  assign err_cnt = err_q;
endmodule

// File: tb/tb_dpsk_word_deframer.sv
// Scoreboard bench for dpsk_word_deframer.
// Expected words queued at stimulus time, popped on handshake.
module tb_dpsk_word_deframer;
  logic       clk1 = 1'b0;
  logic       rst = 1'b0;
  logic       demodulated = 1'b0;
  logic       neg_demodulated = 1'b1;
  logic       bit_valid = 1'b0;
  logic       clr = 1'b0;
  logic       locked;
  logic       overflow;
  logic [7:0] err_cnt;

  dpsk_word_deframer_if #(.W(8)) wif ();

  dpsk_word_deframer dut (
    .clk1           (clk1),
    .rst            (rst),
    .demodulated    (demodulated),
    .neg_demodulated(neg_demodulated),
    .bit_valid      (bit_valid),
    .clr            (clr),
    .wif            (wif),
    .locked         (locked),
    .overflow       (overflow),
    .err_cnt        (err_cnt)
  );

  always #5 clk1 = ~clk1;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_pass = 0;
  int   n_chk = 0;

  always @(negedge clk1) begin
    if (rst && wif.word_valid && wif.word_ready) begin
      n_chk++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_unexpected got=%02h sof=%0b none expected",
                 wif.word_out, wif.word_sof);
      end else begin
        e = sbq.pop_front();
        if ({wif.word_out, wif.word_sof} !== {e.d, e.sof})
          $display("FAIL sb_word got=%02h/%0b exp=%02h/%0b",
                   wif.word_out, wif.word_sof, e.d, e.sof);
        else
          n_pass++;
      end
    end
  end

  task automatic send_bit(input logic b, input logic er);
    demodulated     = b;
    neg_demodulated = er ? b : ~b;
    bit_valid       = 1'b1;
    @(posedge clk1); #1;
    bit_valid = 1'b0;
    @(posedge clk1); #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic er);
    for (int i = 7; i >= 0; i--) send_bit(v[i], er);
  endtask

  task automatic send_word(input logic [7:0] v, input logic s,
                           input logic er);
    sbq.push_back(exp_t'({v, s}));
    send_byte(v, er);
  endtask

  task automatic send_frame(input logic [7:0] base, input logic er);
    for (int i = 0; i < 4; i++)
      send_word(base + 8'(i), (i == 0), er);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    bit_valid = 1'b0;
    clr       = 1'b0;
    sbq.delete();
    repeat (2) @(posedge clk1);
    #1 rst = 1'b1;
    @(posedge clk1); #1;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk1);
    #1;
  endtask

  task automatic test_reset();
    wif.word_ready = 1'b1;
    do_reset();
    n_chk++;
    if ({locked, wif.word_valid, overflow, err_cnt,
         wif.word_out, wif.word_sof} !== 20'h0)
      $display("FAIL reset_state got=%b/%b/%b/%02h/%02h/%b exp=all 0",
               locked, wif.word_valid, overflow, err_cnt,
               wif.word_out, wif.word_sof);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] s;
    s = 8'hA5;
    do_reset();
    wif.word_ready = 1'b1;
    for (int i = 7; i >= 1; i--) send_bit(s[i], 1'b0);
    n_chk++;
    if (locked !== 1'b0)
      $display("FAIL lock_early got=%b exp=0", locked);
    else n_pass++;
    send_bit(s[0], 1'b0);
    n_chk++;
    if (locked !== 1'b1)
      $display("FAIL lock_bit8 got=%b exp=1", locked);
    else n_pass++;
    send_word(8'h11, 1'b1, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0);
    send_word(8'h44, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0);
    settle();
    n_chk++;
    if (sbq.size() != 0 || locked !== 1'b1)
      $display("FAIL basic_drain got=%0d/%b exp=0/1",
               sbq.size(), locked);
    else n_pass++;
  endtask

  task automatic test_garbage();
    do_reset();
    wif.word_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_word(8'h3C, 1'b1, 1'b0);
    send_word(8'hC3, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0);
    send_word(8'h0F, 1'b0, 1'b0);
    settle();
    n_chk++;
    if (sbq.size() != 0 || locked !== 1'b1)
      $display("FAIL garbage_drain got=%0d/%b exp=0/1",
               sbq.size(), locked);
    else n_pass++;
  endtask

  task automatic test_flywheel();
    do_reset();
    wif.word_ready = 1'b1;
    send_byte(8'hA5, 1'b0);
    send_frame(8'h10, 1'b0);
    send_byte(8'hA4, 1'b0);
    n_chk++;
    if (locked !== 1'b1)
      $display("FAIL miss1_locked got=%b exp=1", locked);
    else n_pass++;
    send_frame(8'h20, 1'b0);
    send_byte(8'hA4, 1'b0);
    n_chk++;
    if (locked !== 1'b1)
      $display("FAIL miss2_locked got=%b exp=1", locked);
    else n_pass++;
    send_frame(8'h30, 1'b0);
    send_byte(8'hA4, 1'b0);
    n_chk++;
    if (locked !== 1'b0)
      $display("FAIL miss3_locked got=%b exp=0", locked);
    else n_pass++;
    settle();
    n_chk++;
    if (sbq.size() != 0)
      $display("FAIL fly_drain got=%0d exp=0", sbq.size());
    else n_pass++;
    do_reset();
    wif.word_ready = 1'b1;
    send_byte(8'hA5, 1'b0);
    send_frame(8'h40, 1'b0);
    send_byte(8'hA4, 1'b0);
    send_frame(8'h50, 1'b0);
    send_byte(8'hA5, 1'b0);
    send_frame(8'h60, 1'b0);
    send_byte(8'hA4, 1'b0);
    send_frame(8'h70, 1'b0);
    send_byte(8'hA4, 1'b0);
    n_chk++;
    if (locked !== 1'b1)
      $display("FAIL miss_reset_locked got=%b exp=1", locked);
    else n_pass++;
    send_frame(8'h80, 1'b0);
    settle();
    n_chk++;
    if (sbq.size() != 0)
      $display("FAIL fly2_drain got=%0d exp=0", sbq.size());
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] w;
    do_reset();
    wif.word_ready = 1'b1;
    send_byte(8'hA5, 1'b0);
    wif.word_ready = 1'b0;
    send_word(8'h5A, 1'b1, 1'b0);
    send_byte(8'h66, 1'b0);
    n_chk++;
    if ({overflow, wif.word_valid, wif.word_out, wif.word_sof}
        !== {1'b1, 1'b1, 8'h5A, 1'b1})
      $display("FAIL ovf_hold got=%b/%b/%02h/%b exp=1/1/5a/1",
               overflow, wif.word_valid, wif.word_out, wif.word_sof);
    else n_pass++;
    wif.word_ready = 1'b1;
    settle();
    n_chk++;
    if (sbq.size() != 0 || wif.word_valid !== 1'b0)
      $display("FAIL ovf_drain got=%0d/%b exp=0/0",
               sbq.size(), wif.word_valid);
    else n_pass++;
    clr = 1'b1;
    @(posedge clk1); #1;
    clr = 1'b0;
    n_chk++;
    if (overflow !== 1'b0)
      $display("FAIL ovf_clr got=%b exp=0", overflow);
    else n_pass++;
    wif.word_ready = 1'b0;
    send_word(8'h12, 1'b0, 1'b0);
    w = 8'h34;
    sbq.push_back(exp_t'({w, 1'b0}));
    for (int i = 7; i >= 1; i--) send_bit(w[i], 1'b0);
    wif.word_ready = 1'b1;
    send_bit(w[0], 1'b0);
    settle();
    n_chk++;
    if (sbq.size() != 0 || overflow !== 1'b0)
      $display("FAIL b2b got=%0d/%b exp=0/0", sbq.size(), overflow);
    else n_pass++;
  endtask

  task automatic test_integrity();
    logic [7:0] s;
    s = 8'hA5;
    do_reset();
    wif.word_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      send_byte(8'hA5, 1'b1);
      send_frame(8'(8'h90 + f * 16), 1'b1);
      if (f == 0) begin
        n_chk++;
        if (err_cnt !== 8'd40)
          $display("FAIL err_40 got=%0d exp=40", err_cnt);
        else n_pass++;
      end
    end
    n_chk++;
    if (err_cnt !== 8'd255)
      $display("FAIL err_sat got=%0d exp=255", err_cnt);
    else n_pass++;
    demodulated     = s[7];
    neg_demodulated = s[7];
    bit_valid       = 1'b1;
    clr             = 1'b1;
    @(posedge clk1); #1;
    bit_valid = 1'b0;
    clr       = 1'b0;
    @(posedge clk1); #1;
    n_chk++;
    if (err_cnt !== 8'd1)
      $display("FAIL err_clr_wins got=%0d exp=1", err_cnt);
    else n_pass++;
    for (int i = 6; i >= 0; i--) send_bit(s[i], 1'b0);
    send_word(8'hC3, 1'b1, 1'b0);
    settle();
    n_chk++;
    if (sbq.size() != 0 || err_cnt !== 8'd1)
      $display("FAIL err_drain got=%0d/%0d exp=0/1",
               sbq.size(), err_cnt);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    wif.word_ready = 1'b0;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h77, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    n_chk++;
    if ({wif.word_valid, err_cnt, locked} !== {1'b1, 8'd1, 1'b1})
      $display("FAIL pre_rst got=%b/%0d/%b exp=1/1/1",
               wif.word_valid, err_cnt, locked);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({locked, wif.word_valid, overflow, err_cnt,
         wif.word_out, wif.word_sof} !== 20'h0)
      $display("FAIL mid_rst got=%b/%b/%b/%02h/%02h/%b exp=all 0",
               locked, wif.word_valid, overflow, err_cnt,
               wif.word_out, wif.word_sof);
    else n_pass++;
    sbq.delete();
    wif.word_ready = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b1;
    @(posedge clk1); #1;
    send_byte(8'hA5, 1'b0);
    send_frame(8'h99, 1'b0);
    settle();
    n_chk++;
    if (sbq.size() != 0 || locked !== 1'b1)
      $display("FAIL relock got=%0d/%b exp=0/1", sbq.size(), locked);
    else n_pass++;
  endtask

  initial begin
    wif.word_ready = 1'b1;
    test_reset();
    test_basic();
    test_garbage();
    test_flywheel();
    test_overflow();
    test_integrity();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
